secuenciador_filtro: RTL and testbench
======================================

SECUENCIADOR_FILTRO -- requirements
Module: secuenciador_filtro

Interface
REQ-001 Parameter W, default 25: sample and result width in bits.
REQ-002 Parameter PERIODO, default 16: minimum clocks between two filter launches.
REQ-003 Parameter TIMEOUT, default 15: max clocks waited for filter completion (WATCHDOG_EN only).
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  upstream sample valid.
REQ-007 in_data  input  W  upstream sample.
REQ-008 in_ready  output  1  block accepts a sample this cycle.
REQ-009 f_rx  output  1  one-cycle launch strobe to the filter core.
REQ-010 f_u  output  W  sample presented to the filter core.
REQ-011 f_rx2  input  1  filter core completion pulse.
REQ-012 f_y  input  W  filter core result, valid while f_rx2=1.
REQ-013 out_valid  output  1  result available downstream.
REQ-014 out_data  output  W  captured filter result.
REQ-015 out_ready  input  1  downstream accepts result.
REQ-016 err_to  output  1  sticky watchdog-timeout flag (tied 0 without WATCHDOG_EN).

Function
REQ-017 FSM states: IDLE, LAUNCH, WAIT, HOLD; registered state, registered outputs.
REQ-018 Slot counter: reset to PERIODO-1 (expired); cleared to 0 on each accept; increments to saturation at PERIODO-1.
REQ-019 in_ready = 1 only in IDLE with the slot counter at PERIODO-1.
REQ-020 Accept (in_valid & in_ready): f_u <= in_data; next state LAUNCH.
REQ-021 LAUNCH lasts exactly one cycle, f_rx=1 during it; then WAIT; f_rx=0 in every other state.
REQ-022 f_u holds its value from the accept until the next accept.
REQ-023 WAIT with f_rx2=1: out_data <= f_y, out_valid=1 from the next cycle; state HOLD.
REQ-024 f_rx2 outside WAIT is ignored.
REQ-025 HOLD: out_valid and out_data stable until out_ready=1; on that cycle transfer completes, next state IDLE, out_valid=0 next cycle.
REQ-026 Launch-to-launch spacing is never below PERIODO clocks, regardless of how quickly f_rx2 and out_ready arrive.
REQ-027 in_valid held high continuously yields one launch per max(PERIODO, completion+handshake) clocks; no sample lost or duplicated.
REQ-028 out_data is bit-exact f_y; no arithmetic or width change.

Reset
REQ-029 rst=0 asynchronously forces IDLE, slot counter PERIODO-1, f_rx=0, f_u=0, out_valid=0, out_data=0, err_to=0.
REQ-030 Reset during LAUNCH, WAIT or HOLD discards the in-flight sample; the first post-reset accept is possible on the first clock after release.

Configuration
REQ-031 Macro SECUENCIADOR_WATCHDOG_EN defined: a wait counter cleared on entering WAIT; reaching TIMEOUT without f_rx2 sets err_to (sticky until reset), returns to IDLE, produces no output.
REQ-032 Macro undefined: no wait counter; WAIT persists until f_rx2; err_to constant 0.

Structure
REQ-033 Shared package holds the state encoding (2-bit: IDLE=0, LAUNCH=1, WAIT=2, HOLD=3) and default constants for W, PERIODO, TIMEOUT.
REQ-034 No sub-module; single flat module instantiated alongside pasabajas_5k, f_rx/f_u/f_rx2/f_y wired to rx/u/rx_2/y.

Verification
REQ-035 Reset, in_valid=1, in_data=25'h0000123 -> f_rx=1 for exactly one cycle, one clock after accept; f_u=25'h0000123.
REQ-036 f_rx2 pulse 6 clocks after f_rx with f_y=25'h1ABCDEF, out_ready=1 -> out_valid one cycle, out_data=25'h1ABCDEF.
REQ-037 out_ready=0 for 10 clocks after out_valid -> out_valid/out_data stable all 10 clocks; in_ready=0 throughout.
REQ-038 in_valid held high, 1000 samples from a file, f_rx2 after 3 clocks, out_ready=1 -> launch spacing exactly 16 clocks; 1000 outputs in order.
REQ-039 WATCHDOG_EN, no f_rx2 -> err_to=1 after 15 WAIT clocks; out_valid never asserted; next sample accepted.
REQ-040 rst=0 pulse while in WAIT -> all outputs at reset values immediately; late f_rx2 ignored; no out_valid.

Source files
------------

// File: rtl/secuenciador_filtro_pkg.sv
// secuenciador_filtro shared types: FSM state encoding and
// default sizing constants for the sample sequencer.
package secuenciador_filtro_pkg;

   localparam int W_DEF       = 25;
   localparam int PERIODO_DEF = 16;
   localparam int TIMEOUT_DEF = 15;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LAUNCH = 2'd1,
      S_WAIT   = 2'd2,
      S_HOLD   = 2'd3
   } estado_t;

endpackage

// File: rtl/secuenciador_filtro.sv
// secuenciador_filtro: paces samples into an external filter core
// (pasabajas_5k: f_rx->rx, f_u->u, f_rx2<-rx_2, f_y<-y), at most
// one launch per PERIODO clocks, and hands results downstream.
// Ports: clk, rst (async, active-low); in_valid/in_data/in_ready
// upstream; f_rx/f_u/f_rx2/f_y filter side; out_valid/out_data/
// out_ready downstream; err_to sticky timeout flag.
// Option: define SECUENCIADOR_WATCHDOG_EN to abort a WAIT that sees
// no completion within TIMEOUT clocks (sets err_to).
module secuenciador_filtro
   import secuenciador_filtro_pkg::*;
#(
   parameter int W       = W_DEF,
   parameter int PERIODO = PERIODO_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         in_ready,
   output logic         f_rx,
   output logic [W-1:0] f_u,
   input  logic         f_rx2,
   input  logic [W-1:0] f_y,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   input  logic         out_ready,
   output logic         err_to
);

   localparam int SW = (PERIODO > 1) ? $clog2(PERIODO) : 1;
   localparam logic [SW-1:0] SLOT_MAX = SW'(PERIODO - 1);

   estado_t       st_q, st_d;
   logic [SW-1:0] slot_q, slot_d;
   logic          acepta, fin, tmo;
   logic          f_rx_d, out_valid_d;
   logic [W-1:0]  f_u_d, out_data_d;

   assign in_ready = (st_q == S_IDLE) && (slot_q == SLOT_MAX);
   assign acepta   = in_valid & in_ready;
   assign fin      = (st_q == S_WAIT) & f_rx2;

`ifdef SECUENCIADOR_WATCHDOG_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] wcnt_q;

   // wait counter is zeroed during LAUNCH, i.e. on entry to WAIT
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wcnt_q <= '0;
         err_to <= 1'b0;
      end else begin
         if (st_q == S_LAUNCH)
            wcnt_q <= '0;
         else if (st_q == S_WAIT)
            wcnt_q <= wcnt_q + 1'b1;
         if (tmo)
            err_to <= 1'b1;
      end
   end

   assign tmo = (st_q == S_WAIT) & ~f_rx2
              & (wcnt_q == TW'(TIMEOUT - 1));
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT;
   assign tmo    = 1'b0;
   assign err_to = 1'b0;
`endif

   // state and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st_q      <= S_IDLE;
         slot_q    <= SLOT_MAX;
         f_rx      <= 1'b0;
         f_u       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         st_q      <= st_d;
         slot_q    <= slot_d;
         f_rx      <= f_rx_d;
         f_u       <= f_u_d;
         out_valid <= out_valid_d;
         out_data  <= out_data_d;
      end
   end

   // next state; slot counter saturates so it doubles as the
   // "period expired" indication
   always_comb begin
      st_d = st_q;
      unique case (st_q)
         S_IDLE:   if (acepta) st_d = S_LAUNCH;
         S_LAUNCH: st_d = S_WAIT;
         S_WAIT: begin
            if (f_rx2)    st_d = S_HOLD;
            else if (tmo) st_d = S_IDLE;
         end
         S_HOLD:   if (out_ready) st_d = S_IDLE;
      endcase
      if (acepta)
         slot_d = '0;
      else if (slot_q == SLOT_MAX)
         slot_d = slot_q;
      else
         slot_d = slot_q + 1'b1;
   end

   // next values of the registered outputs
   always_comb begin
      f_rx_d      = (st_d == S_LAUNCH);
      out_valid_d = (st_d == S_HOLD);
      f_u_d       = acepta ? in_data : f_u;
      out_data_d  = fin ? f_y : out_data;
   end

endmodule

// File: tb/tb_secuenciador_filtro.sv
// Directed bench for secuenciador_filtro with immediate assertions.
// Default parameters (W=25, PERIODO=16, TIMEOUT=15).
module tb_secuenciador_filtro;

   localparam int W = 25;
   localparam logic [W-1:0] K = 25'h1555555;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic [W-1:0] in_data;
   logic         in_ready;
   logic         f_rx;
   logic [W-1:0] f_u;
   logic         f_rx2;
   logic [W-1:0] f_y;
   logic         out_valid;
   logic [W-1:0] out_data;
   logic         out_ready;
   logic         err_to;

   int npass = 0;
   int ntot  = 0;

   secuenciador_filtro dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .f_rx      (f_rx),
      .f_u       (f_u),
      .f_rx2     (f_rx2),
      .f_y       (f_y),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .err_to    (err_to)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      ntot++;
      assert (got === exp) begin
         npass++;
      end else begin
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      for (int i = 0; i < 40 && in_ready !== 1'b1; i++) tick();
      chk("ready_wait", 32'(in_ready), 32'd1);
   endtask

   logic [W-1:0] q[$];
   logic [W-1:0] nxt;
   logic [W-1:0] exp_v;
   int last_l, frx2_at, nout, nlaunch;

   initial begin
      rst = 1'b0; in_valid = 1'b0; in_data = '0;
      f_rx2 = 1'b0; f_y = '0; out_ready = 1'b0;
      tick(); tick();
      chk("rst_f_rx", 32'(f_rx), 32'd0);
      chk("rst_f_u", 32'(f_u), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_err_to", 32'(err_to), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      // first accept right after release
      rst = 1'b1; in_valid = 1'b1; in_data = 25'h0000123;
      tick();
      chk("acc_f_rx", 32'(f_rx), 32'd1);
      chk("acc_f_u", 32'(f_u), 32'h123);
      chk("acc_in_ready", 32'(in_ready), 32'd0);
      in_valid = 1'b0;
      tick();
      chk("f_rx_one_cycle", 32'(f_rx), 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("wait_no_out", 32'(out_valid), 32'd0);
      end
      f_rx2 = 1'b1; f_y = 25'h1ABCDEF; out_ready = 1'b1;
      tick();
      chk("res_valid", 32'(out_valid), 32'd1);
      chk("res_data", 32'(out_data), 32'h1ABCDEF);
      f_rx2 = 1'b0;
      tick();
      chk("res_one_cycle", 32'(out_valid), 32'd0);
      // completion pulse while idle must be ignored
      f_rx2 = 1'b1; f_y = 25'h0F0F0F0;
      tick();
      f_rx2 = 1'b0;
      chk("stray_valid", 32'(out_valid), 32'd0);
      chk("stray_data", 32'(out_data), 32'h1ABCDEF);

      // downstream back-pressure
      out_ready = 1'b0; in_valid = 1'b1; in_data = 25'h00ABCDE;
      wait_ready();
      tick();
      chk("bp_f_rx", 32'(f_rx), 32'd1);
      chk("bp_f_u", 32'(f_u), 32'hABCDE);
      tick();
      f_rx2 = 1'b1; f_y = 25'h0155555;
      tick();
      f_rx2 = 1'b0;
      for (int i = 0; i < 10; i++) begin
         chk("bp_hold",
             {5'd0, in_ready, out_valid, out_data},
             {5'd0, 1'b0, 1'b1, 25'h0155555});
         tick();
      end
      chk("bp_still", 32'(out_valid), 32'd1);
      out_ready = 1'b1;
      tick();
      chk("bp_release", 32'(out_valid), 32'd0);

      // continuous stream, completion 3 clocks after launch
      last_l = -1; frx2_at = -1; nout = 0; nlaunch = 0;
      nxt = 25'h0100000; in_data = nxt; in_valid = 1'b1;
      for (int c = 0; c < 700 && nout < 20; c++) begin
         tick();
         f_rx2 = 1'b0;
         if (f_rx === 1'b1) begin
            if (last_l >= 0) chk("spacing", 32'(c - last_l), 32'd16);
            chk("stream_f_u", 32'(f_u), 32'(nxt));
            q.push_back(nxt);
            last_l = c; frx2_at = c + 3; nlaunch++;
            nxt = nxt + 25'h0000101; in_data = nxt;
            if (nlaunch == 20) in_valid = 1'b0;
         end
         if (c == frx2_at) begin
            f_rx2 = 1'b1;
            f_y = q[q.size() - 1] ^ K;
         end
         if (out_valid === 1'b1) begin
            exp_v = (q.size() > 0) ? (q.pop_front() ^ K) : '1;
            chk("stream_out", 32'(out_data), 32'(exp_v));
            nout++;
         end
      end
      f_rx2 = 1'b0;
      chk("stream_count", 32'(nout), 32'd20);
      chk("stream_launches", 32'(nlaunch), 32'd20);

      // reset while in WAIT
      wait_ready();
      in_valid = 1'b1; in_data = 25'h0777777;
      tick();
      chk("rw_f_rx", 32'(f_rx), 32'd1);
      in_valid = 1'b0;
      tick();
      #2;
      rst = 1'b0;
      #1;
      chk("rw_async",
          {27'd0, f_rx, out_valid, err_to, in_ready, 1'b0},
          {27'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
      chk("rw_f_u", 32'(f_u), 32'd0);
      chk("rw_out_data", 32'(out_data), 32'd0);
      tick();
      rst = 1'b1; f_rx2 = 1'b1; f_y = 25'h1111111;
      in_valid = 1'b1; in_data = 25'h0000456;
      tick();
      chk("rw_first_acc", 32'(f_rx), 32'd1);
      chk("rw_first_f_u", 32'(f_u), 32'h456);
      chk("rw_late_ignored", 32'(out_valid), 32'd0);
      f_rx2 = 1'b0; in_valid = 1'b0;

`ifdef SECUENCIADOR_WATCHDOG_EN
      for (int i = 1; i <= 15; i++) begin
         tick();
         chk("wd_pre", {30'd0, err_to, out_valid}, 32'd0);
      end
      tick();
      chk("wd_err", 32'(err_to), 32'd1);
      chk("wd_no_out", 32'(out_valid), 32'd0);
      chk("wd_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1; in_data = 25'h0000999;
      tick();
      in_valid = 1'b0;
      chk("wd_next_acc", 32'(f_rx), 32'd1);
      chk("wd_next_f_u", 32'(f_u), 32'h999);
      chk("wd_sticky", 32'(err_to), 32'd1);
`else
      for (int i = 0; i < 30; i++) begin
         tick();
         chk("nowd_wait",
             {29'd0, err_to, out_valid, in_ready}, 32'd0);
      end
      f_rx2 = 1'b1; f_y = 25'h0ACE123;
      tick();
      f_rx2 = 1'b0;
      chk("nowd_late_done", 32'(out_valid), 32'd1);
      chk("nowd_late_data", 32'(out_data), 32'h0ACE123);
`endif

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
